// File: rtl/window_box_overlay.sv
// Draws the per-frame bounding box of an extreme-point window onto an RGB stream (2-cycle latency).
// Optional centre crosshair enabled by defining WINDOW_BOX_CROSS_EN.
module window_box_overlay #(
  parameter int          H_ACT       = 640,
  parameter int          V_ACT       = 480,
  parameter int          LINE_W      = 2,
  parameter logic [23:0] BOX_COLOR   = 24'hFF0000,
  parameter int          HOLD_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vs_in,
  input  logic        hs_in,
  input  logic        de_in,
  input  logic [23:0] rgb_in,
  input  logic [79:0] win,
  output logic        vs_out,
  output logic        hs_out,
  output logic        de_out,
  output logic [23:0] rgb_out,
  output logic        box_valid
);

  localparam logic [9:0]  X_LAST = 10'(H_ACT - 1);
  localparam logic [9:0]  Y_LAST = 10'(V_ACT - 1);
  localparam logic [10:0] LW     = 11'(LINE_W);
  localparam logic [3:0]  HOLD_N = 4'(HOLD_FRAMES);

  typedef enum logic [1:0] {S_NONE, S_TRACK, S_HOLD} state_t;

  state_t      state;
  logic [3:0]  hold_cnt;
  logic        vs_d, de_d;
  logic [9:0]  x_cnt, y_cnt;
  logic [9:0]  bx_min, bx_max, by_min, by_max;

  logic        vs_rise, de_fall;
  logic [9:0]  pix_x, pix_y;
  logic [9:0]  c_x_min, c_x_max, c_y_min, c_y_max;
  logic        c_valid;

  logic        vs_1, hs_1, de_1, flag_1;
  logic [23:0] rgb_1;

  function automatic logic [9:0] inc_sat(input logic [9:0] v, input logic [9:0] last);
    return (v == last) ? v : v + 10'd1;
  endfunction

  assign vs_rise   = vs_in & ~vs_d;
  assign de_fall   = de_d & ~de_in;
  assign box_valid = (state != S_NONE);

  // A pixel coinciding with the frame-start edge is treated as (0,0).
  assign pix_x = vs_rise ? '0 : x_cnt;
  assign pix_y = vs_rise ? '0 : y_cnt;

  assign c_y_min = win[69:60];
  assign c_y_max = win[49:40];
  assign c_x_min = win[39:30];
  assign c_x_max = win[19:10];
  assign c_valid = (c_x_min <= c_x_max) && (c_y_min <= c_y_max);

  // NOTE: synchronous reset; every sequential block checks rst_n inside the clocked branch and uses <= only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_d  <= 1'b0;
      de_d  <= 1'b0;
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      vs_d <= vs_in;
      de_d <= de_in;
      if (vs_rise) begin
        x_cnt <= de_in ? inc_sat('0, X_LAST) : '0;
        y_cnt <= '0;
      end else if (de_in) begin
        x_cnt <= inc_sat(x_cnt, X_LAST);
      end else if (de_fall) begin
        x_cnt <= '0;
        y_cnt <= inc_sat(y_cnt, Y_LAST);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_NONE;
      hold_cnt <= '0;
      bx_min   <= '0;
      bx_max   <= '0;
      by_min   <= '0;
      by_max   <= '0;
    end else if (vs_rise) begin
      if (c_valid) begin
        state    <= S_TRACK;
        hold_cnt <= '0;
        bx_min   <= c_x_min;
        bx_max   <= c_x_max;
        by_min   <= c_y_min;
        by_max   <= c_y_max;
      end else begin
        case (state)
          S_TRACK: begin
            state    <= S_HOLD;
            hold_cnt <= 4'd1;
          end
          S_HOLD: begin
            if (hold_cnt >= HOLD_N) begin
              state    <= S_NONE;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + 4'd1;
            end
          end
          default: begin
            state    <= S_NONE;
            hold_cnt <= '0;
          end
        endcase
      end
    end
  end

  // Border test: distances are formed in 11 bits and only used when the pixel is inside the box.
  logic        in_box, on_edge, on_cross, border;
  logic [10:0] d_left, d_right, d_top, d_bot;

  assign in_box  = (pix_x >= bx_min) && (pix_x <= bx_max) &&
                   (pix_y >= by_min) && (pix_y <= by_max);
  assign d_left  = {1'b0, pix_x}  - {1'b0, bx_min};
  assign d_right = {1'b0, bx_max} - {1'b0, pix_x};
  assign d_top   = {1'b0, pix_y}  - {1'b0, by_min};
  assign d_bot   = {1'b0, by_max} - {1'b0, pix_y};
  assign on_edge = (d_left < LW) || (d_right < LW) || (d_top < LW) || (d_bot < LW);

`ifdef WINDOW_BOX_CROSS_EN
  logic [9:0]  cx, cy;
  logic [10:0] sum_x, sum_y;

  assign sum_x = {1'b0, c_x_min} + {1'b0, c_x_max};
  assign sum_y = {1'b0, c_y_min} + {1'b0, c_y_max};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cx <= '0;
      cy <= '0;
    end else if (vs_rise && c_valid) begin
      cx <= sum_x[10:1];
      cy <= sum_y[10:1];
    end
  end

  assign on_cross = (pix_x == cx) || (pix_y == cy);
`else
  assign on_cross = 1'b0;
`endif

  assign border = de_in && box_valid && in_box && (on_edge || on_cross);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_1    <= 1'b0;
      hs_1    <= 1'b0;
      de_1    <= 1'b0;
      flag_1  <= 1'b0;
      rgb_1   <= '0;
      vs_out  <= 1'b0;
      hs_out  <= 1'b0;
      de_out  <= 1'b0;
      rgb_out <= '0;
    end else begin
      vs_1    <= vs_in;
      hs_1    <= hs_in;
      de_1    <= de_in;
      flag_1  <= border;
      rgb_1   <= rgb_in;
      vs_out  <= vs_1;
      hs_out  <= hs_1;
      de_out  <= de_1;
      rgb_out <= !de_1 ? '0 : (flag_1 ? BOX_COLOR : rgb_1);
    end
  end

endmodule

// File: tb/tb_window_box_overlay.sv
// Self-checking bench for window_box_overlay: random video checked against a frame-level reference model.
// Build with WINDOW_BOX_CROSS_EN defined to exercise the crosshair expectations.
module tb_window_box_overlay;

  localparam int          H_ACT       = 640;
  localparam int          V_ACT       = 480;
  localparam int          LINE_W      = 2;
  localparam logic [23:0] BOX_COLOR   = 24'hFF0000;
  localparam int          HOLD_FRAMES = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
  logic [23:0] rgb_in = '0;
  logic [79:0] win = '0;
  logic        vs_out, hs_out, de_out, box_valid;
  logic [23:0] rgb_out;

  window_box_overlay #(
    .H_ACT(H_ACT), .V_ACT(V_ACT), .LINE_W(LINE_W),
    .BOX_COLOR(BOX_COLOR), .HOLD_FRAMES(HOLD_FRAMES)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in), .rgb_in(rgb_in), .win(win),
    .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out), .rgb_out(rgb_out),
    .box_valid(box_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vs, hs, de;
    logic [23:0] rgb;
    logic [23:0] rgb_in;
    int          x, y;
    bit          big;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state: whether a box is shown, its extent, and consecutive empty frames seen.
  bit   m_on = 0;
  int   m_miss = 0;
  int   mx0 = 0, mx1 = 0, my0 = 0, my1 = 0;
  bit   m_vs_prev = 0;

  localparam logic [79:0] EMPTY_WIN = {10'd1023, 10'd1023, 10'd0, 10'd0,
                                       10'd1023, 10'd1023, 10'd0, 10'd0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] mk_win(input int tx, ty, bx, by, lx, ly, rx, ry);
    return {10'(tx), 10'(ty), 10'(bx), 10'(by), 10'(lx), 10'(ly), 10'(rx), 10'(ry)};
  endfunction

  function automatic logic [79:0] rnd80();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[79:0];
  endfunction

  function automatic logic [23:0] rnd_rgb();
    logic [23:0] c;
    c = 24'($urandom);
    if (c == BOX_COLOR) c = c ^ 24'h000001;
    return c;
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Frame-start rule: a non-empty window replaces the box; empty windows are tolerated HOLD_FRAMES times.
  task automatic model_latch(input logic [79:0] w);
    int ymin, ymax, xmin, xmax;
    ymin = int'(w[69:60]); ymax = int'(w[49:40]);
    xmin = int'(w[39:30]); xmax = int'(w[19:10]);
    if (xmin <= xmax && ymin <= ymax) begin
      mx0 = xmin; mx1 = xmax; my0 = ymin; my1 = ymax;
      m_on = 1; m_miss = 0;
    end else if (m_on) begin
      m_miss++;
      if (m_miss > HOLD_FRAMES) begin
        m_on = 0; m_miss = 0;
      end
    end
  endtask

  function automatic logic [23:0] model_pixel(input logic de, input logic [23:0] rgb, input int x, input int y);
    int d;
    if (!de) return 24'h0;
    if (m_on && x >= mx0 && x <= mx1 && y >= my0 && y <= my1) begin
      d = min2(min2(x - mx0, mx1 - x), min2(y - my0, my1 - y));
      if (d < LINE_W) return BOX_COLOR;
`ifdef WINDOW_BOX_CROSS_EN
      if (x == (mx0 + mx1) / 2 || y == (my0 + my1) / 2) return BOX_COLOR;
`endif
    end
    return rgb;
  endfunction

  // 1 = must be box colour, 2 = must pass rgb through, 0 = no directed expectation.
  function automatic int dir_kind(input int x, input int y);
    if ((x == 30 && y == 50) || (x == 31 && y == 60) ||
        (x == 300 && y == 199) || (x == 150 && y == 200)) return 1;
    if ((x == 32 && y == 60) || (x == 150 && y == 197) || (x == 165 && y == 40)) return 2;
`ifdef WINDOW_BOX_CROSS_EN
    if ((x == 165 && y == 120) || (x == 40 && y == 125)) return 1;
`else
    if (x == 165 && y == 120) return 2;
`endif
    return 0;
  endfunction

  task automatic cyc(input logic vs, input logic hs, input logic de, input int x, input int y, input bit big);
    exp_t e;
    int   k;
    vs_in  = vs;
    hs_in  = hs;
    de_in  = de;
    rgb_in = rnd_rgb();
    if (vs && !m_vs_prev) model_latch(win);
    m_vs_prev = vs;
    e.vs     = vs;
    e.hs     = hs;
    e.de     = de;
    e.x      = min2(x, H_ACT - 1);
    e.y      = min2(y, V_ACT - 1);
    e.rgb_in = rgb_in;
    e.rgb    = model_pixel(de, rgb_in, e.x, e.y);
    e.big    = big;
    q.push_back(e);
    @(posedge clk);
    #1;
    check("box_valid", 32'(box_valid), 32'(m_on));
    if (q.size() >= 2) begin
      e = q.pop_front();
      check("vs_out", 32'(vs_out), 32'(e.vs));
      check("hs_out", 32'(hs_out), 32'(e.hs));
      check("de_out", 32'(de_out), 32'(e.de));
      check("rgb_out", 32'(rgb_out), 32'(e.rgb));
      if (e.big && e.de) begin
        k = dir_kind(e.x, e.y);
        if (k == 1) check($sformatf("dir_box(%0d,%0d)", e.x, e.y), 32'(rgb_out), 32'(BOX_COLOR));
        if (k == 2) check($sformatf("dir_pass(%0d,%0d)", e.x, e.y), 32'(rgb_out), 32'(e.rgb_in));
      end
    end
  endtask

  task automatic do_reset(input int n);
    exp_t z;
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      vs_in  = 1'b0;
      hs_in  = 1'(i == 0);
      de_in  = 1'b1;
      rgb_in = rnd_rgb();
      @(posedge clk);
      #1;
      check("rst_vs_out", 32'(vs_out), 32'h0);
      check("rst_hs_out", 32'(hs_out), 32'h0);
      check("rst_de_out", 32'(de_out), 32'h0);
      check("rst_rgb_out", 32'(rgb_out), 32'h0);
      check("rst_box_valid", 32'(box_valid), 32'h0);
    end
    rst_n = 1'b1;
    m_on = 0; m_miss = 0; m_vs_prev = 0;
    q.delete();
    z.vs = 0; z.hs = 0; z.de = 0; z.rgb = '0; z.rgb_in = '0; z.x = 0; z.y = 0; z.big = 0;
    q.push_back(z);
  endtask

  function automatic bit big_line(input int y);
    return (y == 40 || y == 50 || y == 60 || y == 120 ||
            y == 125 || y == 197 || y == 199 || y == 200);
  endfunction

  // One frame: sync pulse with w presented only on the rising vs edge, then lines with random win noise.
  task automatic run_frame(input logic [79:0] w, input int nlines, input int len,
                           input bit big, input int rst_line);
    int l;
    win = w;
    cyc(1, 0, 0, 0, 0, big);
    win = rnd80();
    cyc(1, 0, 0, 0, 0, big);
    cyc(0, 0, 0, 0, 0, big);
    cyc(0, 0, 0, 0, 0, big);
    for (int y = 0; y < nlines; y++) begin
      if (y == rst_line) do_reset(2);
      win = rnd80();
      l = big ? (big_line(y) ? 302 : 1) : len;
      cyc(0, 1, 0, 0, y, big);
      cyc(0, 0, 0, 0, y, big);
      for (int x = 0; x < l; x++) cyc(0, 0, 1, x, y, big);
      cyc(0, 0, 0, 0, y, big);
    end
    cyc(0, 0, 0, 0, 0, big);
    cyc(0, 0, 0, 0, 0, big);
  endtask

  logic [79:0] test_win;
  logic [79:0] small_win;
  logic [79:0] rw;

  initial begin
    test_win  = mk_win(100, 50, 120, 200, 30, 120, 300, 90);
    small_win = mk_win(9, 52, 11, 55, 5, 53, 20, 54);

    do_reset(3);
    run_frame(EMPTY_WIN, 20, 40, 0, -1);
    check("bv_after_empty", 32'(box_valid), 32'h0);

    run_frame(test_win, 202, 0, 1, -1);
    check("bv_track", 32'(box_valid), 32'h1);

    for (int i = 0; i < 5; i++) begin
      run_frame(EMPTY_WIN, 56, 40, 0, -1);
      check($sformatf("bv_hold%0d", i + 1), 32'(box_valid), 32'(i < HOLD_FRAMES));
    end

    run_frame(test_win, 56, 40, 0, -1);
    for (int i = 0; i < 2; i++) run_frame(EMPTY_WIN, 56, 40, 0, -1);
    run_frame(small_win, 56, 24, 0, -1);
    check("bv_recover", 32'(box_valid), 32'h1);
    for (int i = 0; i < 5; i++) begin
      run_frame(EMPTY_WIN, 56, 24, 0, -1);
      check($sformatf("bv_rehold%0d", i + 1), 32'(box_valid), 32'(i < HOLD_FRAMES));
    end

    // Box hugging the last column: pixels past H_ACT-1 must stay at the saturated x.
    run_frame(mk_win(0, 0, 0, 3, 630, 0, 639, 0), 4, 700, 0, -1);

    run_frame(mk_win(0, 2, 0, 20, 3, 0, 30, 0), 24, 36, 0, 10);
    check("bv_after_midreset", 32'(box_valid), 32'h0);
    run_frame(EMPTY_WIN, 24, 36, 0, -1);

    for (int i = 0; i < 10; i++) begin
      case (i % 4)
        0: rw = mk_win(0, $urandom_range(0, 25), 0, $urandom_range(0, 25),
                       $urandom_range(0, 40), 0, $urandom_range(0, 40), 0);
        1: rw = mk_win(0, 7, 0, 7, $urandom_range(0, 10), 0, $urandom_range(20, 40), 0);
        2: rw = mk_win(0, $urandom_range(0, 8), 0, $urandom_range(12, 25), 17, 0, 17, 0);
        default: rw = EMPTY_WIN;
      endcase
      run_frame(rw, 28, 44, 0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
